// File: rtl/block_map_pkg.sv
// Shared types and defaults for the brick-field HP map: FSM state, HP type and the
// level-to-HP initial pattern.
package block_map_pkg;

  localparam int DEF_COLS = 16;
  localparam int DEF_ROWS = 8;
  localparam int DEF_HP_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    ACTIVE  = 2'd2,
    CLEARED = 2'd3
  } state_t;

  typedef logic [DEF_HP_W-1:0] hp_t;

  // odd is (row+col) mod 2 of the cell being initialised.
  function automatic hp_t level_hp(input logic [3:0] lvl, input logic odd);
    hp_t hp;
    case (lvl)
      4'd0, 4'd1: hp = hp_t'(1);
      4'd2:       hp = hp_t'(2);
      4'd3:       hp = odd ? hp_t'(1) : hp_t'(3);
      default:    hp = hp_t'(3);
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/block_hp_ram.sv
// Cell HP storage: one synchronous write port plus two registered read ports
// (hit RMW and drawing path), both read-before-write.
module block_hp_ram #(
  parameter int DEPTH = 128,
  parameter int HP_W  = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [HP_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] rmw_addr,
  output logic [HP_W-1:0]          rmw_data,
  input  logic [$clog2(DEPTH)-1:0] drw_addr,
  output logic [HP_W-1:0]          drw_data
);

  logic [HP_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rmw_data <= mem[rmw_addr];
    drw_data <= mem[drw_addr];
  end

endmodule

// File: rtl/block_map_writer.sv
// Live brick-field HP map: level load, two-cycle hit read-modify-write, block count
// and level-clear detection. Optional score output under BLOCK_MAP_SCORE_EN.
module block_map_writer
  import block_map_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int HP_W = DEF_HP_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_level,
  input  logic [3:0]                 level,
  input  logic                       hit_valid,
  output logic                       hit_ready,
  input  logic [$clog2(COLS)-1:0]    hit_col,
  input  logic [$clog2(ROWS)-1:0]    hit_row,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  input  logic [$clog2(ROWS)-1:0]    rd_row,
  output logic [HP_W-1:0]            rd_hp,
  output logic [$clog2(COLS*ROWS):0] blocks_left,
  output logic                       block_destroyed,
  output logic                       level_clear,
  output logic                       busy
`ifdef BLOCK_MAP_SCORE_EN
  ,
  output logic [15:0]                score
`endif
);

  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(COLS);
  localparam int BW = AW + 1;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt;
  logic [3:0]      level_q;
  logic [HP_W-1:0] init_hp;
  logic            hit_acc;
  logic            hit_inr;
  logic            vld_p1;
  logic            inr_p1;
  logic [AW-1:0]   addr_p1;
  logic [HP_W-1:0] rmw_data;
  logic [HP_W-1:0] drw_data;
  logic            wr_eff;
  logic            destroy;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [HP_W-1:0] wdata;

  assign init_hp = HP_W'(level_hp(level_q, cnt[0] ^ cnt[CW]));
  assign hit_inr = (int'(hit_col) < COLS) && (int'(hit_row) < ROWS);
  assign hit_acc = hit_valid && hit_ready;

  // Write stage: a pending hit lands only if the cell still has HP and no reload aborts it.
  assign wr_eff  = vld_p1 && inr_p1 && (rmw_data != '0) && (state == ACTIVE)
                   && !load_level && !reset;
  assign destroy = wr_eff && (rmw_data == HP_W'(1));

  always_comb begin
    state_nx        = state;
    hit_ready       = 1'b0;
    busy            = 1'b0;
    rd_hp           = '0;
    block_destroyed = destroy;
    we              = wr_eff;
    waddr           = addr_p1;
    wdata           = rmw_data - HP_W'(1);
    case (state)
      INIT: begin
        busy  = 1'b1;
        we    = !load_level;
        waddr = cnt;
        wdata = init_hp;
        if (cnt == AW'(N - 1)) state_nx = ACTIVE;
      end
      ACTIVE: begin
        hit_ready = !vld_p1;
        rd_hp     = drw_data;
        if (destroy && (blocks_left == BW'(1))) state_nx = CLEARED;
      end
      default: ;
    endcase
    if (load_level) state_nx = INIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      blocks_left <= '0;
      vld_p1      <= 1'b0;
      level_clear <= 1'b0;
    end else begin
      state       <= state_nx;
      level_clear <= 1'b0;
      if (load_level) begin
        cnt         <= '0;
        blocks_left <= '0;
        vld_p1      <= 1'b0;
      end else begin
        vld_p1 <= hit_acc;
        if (state == INIT) begin
          cnt <= cnt + AW'(1);
          if (init_hp != '0) blocks_left <= blocks_left + BW'(1);
        end
        if (destroy) begin
          blocks_left <= blocks_left - BW'(1);
          if (blocks_left == BW'(1)) level_clear <= 1'b1;
        end
      end
    end
  end

  // Accept stage: capture the hit address alongside the RAM read.
  always_ff @(posedge clk) begin
    if (load_level) level_q <= level;
    if (hit_acc) begin
      addr_p1 <= {hit_row, hit_col};
      inr_p1  <= hit_inr;
    end
  end

  block_hp_ram #(.DEPTH(N), .HP_W(HP_W)) u_ram (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rmw_addr ({hit_row, hit_col}),
    .rmw_data (rmw_data),
    .drw_addr ({rd_row, rd_col}),
    .drw_data (drw_data)
  );

`ifdef BLOCK_MAP_SCORE_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset || load_level) score <= '0;
    else if (wr_eff)         score <= sat_add16(score, destroy ? 3'd5 : 3'd1);
  end
`endif

endmodule

// File: tb/tb_block_map_writer.sv
// Directed bench for block_map_writer: reset, level load timing, HP patterns, hit RMW,
// level clear and reload aborts.
module tb_block_map_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_level;
  logic [3:0] level;
  logic       hit_valid;
  logic       hit_ready;
  logic [3:0] hit_col;
  logic [2:0] hit_row;
  logic [3:0] rd_col;
  logic [2:0] rd_row;
  logic [1:0] rd_hp;
  logic [7:0] blocks_left;
  logic       block_destroyed;
  logic       level_clear;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int dcnt;

  always #5 clk = ~clk;

  block_map_writer dut (
    .clk             (clk),
    .reset           (reset),
    .load_level      (load_level),
    .level           (level),
    .hit_valid       (hit_valid),
    .hit_ready       (hit_ready),
    .hit_col         (hit_col),
    .hit_row         (hit_row),
    .rd_col          (rd_col),
    .rd_row          (rd_row),
    .rd_hp           (rd_hp),
    .blocks_left     (blocks_left),
    .block_destroyed (block_destroyed),
    .level_clear     (level_clear),
    .busy            (busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse load_level; returns in the first INIT cycle.
  task automatic load(input logic [3:0] lv);
    load_level = 1'b1;
    level      = lv;
    cyc();
    load_level = 1'b0;
  endtask

  task automatic read_cell(input logic [2:0] r, input logic [3:0] c, input logic [1:0] exp,
                           input string tag);
    rd_row = r;
    rd_col = c;
    cyc();
    chk(tag, 32'(rd_hp), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; load_level = 1'b0; level = 4'd0; hit_valid = 1'b0;
    hit_col = '0; hit_row = '0; rd_col = '0; rd_row = '0;
    repeat (2) cyc();
    chk("rst_ready",  32'(hit_ready), 0);
    chk("rst_rdhp",   32'(rd_hp), 0);
    chk("rst_left",   32'(blocks_left), 0);
    chk("rst_destr",  32'(block_destroyed), 0);
    chk("rst_clear",  32'(level_clear), 0);
    chk("rst_busy",   32'(busy), 0);
    reset = 1'b0;
    cyc();
    chk("idle_ready", 32'(hit_ready), 0);

    // Level 1: INIT is exactly 128 cycles, blocks_left counts up.
    load(4'd1);
    chk("l1_busy_first", 32'(busy), 1);
    chk("l1_left_first", 32'(blocks_left), 0);
    chk("l1_ready_init", 32'(hit_ready), 0);
    repeat (127) cyc();
    chk("l1_busy_last",  32'(busy), 1);
    chk("l1_left_last",  32'(blocks_left), 127);
    chk("l1_rdhp_init",  32'(rd_hp), 0);
    cyc();
    chk("l1_busy_done",  32'(busy), 0);
    chk("l1_left_done",  32'(blocks_left), 128);
    chk("l1_ready_act",  32'(hit_ready), 1);

    // Level 3 checkerboard pattern.
    load(4'd3);
    repeat (128) cyc();
    read_cell(3'd0, 4'd0,  2'd3, "l3_r0c0");
    read_cell(3'd0, 4'd1,  2'd1, "l3_r0c1");
    read_cell(3'd1, 4'd1,  2'd3, "l3_r1c1");
    read_cell(3'd3, 4'd4,  2'd1, "l3_r3c4");
    read_cell(3'd7, 4'd15, 2'd3, "l3_r7c15");
    chk("l3_left", 32'(blocks_left), 128);

    // Level 2: three hits on (row 2, col 5) with hit_valid held throughout.
    load(4'd2);
    repeat (128) cyc();
    hit_row = 3'd2; hit_col = 4'd5; hit_valid = 1'b1;
    chk("h1_ready", 32'(hit_ready), 1);
    cyc();
    chk("h1w_ready", 32'(hit_ready), 0);
    chk("h1w_destr", 32'(block_destroyed), 0);
    cyc();
    chk("h2_ready", 32'(hit_ready), 1);
    chk("h2_left",  32'(blocks_left), 128);
    cyc();
    chk("h2w_ready", 32'(hit_ready), 0);
    chk("h2w_destr", 32'(block_destroyed), 1);
    rd_row = 3'd2; rd_col = 4'd5;
    cyc();
    chk("h3_ready", 32'(hit_ready), 1);
    chk("h3_left",  32'(blocks_left), 127);
    chk("h3_rbw",   32'(rd_hp), 1);
    cyc();
    chk("h3w_destr", 32'(block_destroyed), 0);
    chk("h3w_rdhp",  32'(rd_hp), 0);
    hit_valid = 1'b0;
    cyc();
    chk("h3_left_after", 32'(blocks_left), 127);
    chk("h3_ready_after", 32'(hit_ready), 1);
    cyc();
    chk("h3_destr_idle", 32'(block_destroyed), 0);

    // Level 1: clear 127 cells, then the last one ends the level.
    load(4'd1);
    repeat (128) cyc();
    dcnt = 0;
    for (int a = 0; a < 127; a++) begin
      hit_row = 3'(a / 16); hit_col = 4'(a % 16); hit_valid = 1'b1;
      cyc();
      if (block_destroyed === 1'b1) dcnt++;
      cyc();
    end
    chk("lc_pulses", 32'(dcnt), 127);
    chk("lc_left1",  32'(blocks_left), 1);
    hit_row = 3'd7; hit_col = 4'd15;
    chk("lc_ready",  32'(hit_ready), 1);
    cyc();
    hit_valid = 1'b0;
    chk("lc_destr",  32'(block_destroyed), 1);
    chk("lc_noclr_yet", 32'(level_clear), 0);
    cyc();
    chk("lc_clear",  32'(level_clear), 1);
    chk("lc_left0",  32'(blocks_left), 0);
    chk("lc_ready0", 32'(hit_ready), 0);
    hit_valid = 1'b1;
    cyc();
    chk("lc_pulse_end", 32'(level_clear), 0);
    chk("cl_ready", 32'(hit_ready), 0);
    chk("cl_rdhp",  32'(rd_hp), 0);
    chk("cl_busy",  32'(busy), 0);
    hit_valid = 1'b0;

    // Reload at INIT cycle 40 restarts from cell 0 with the new level.
    load(4'd2);
    repeat (39) cyc();
    chk("ab_left40", 32'(blocks_left), 39);
    load(4'd3);
    chk("ab_restart_left", 32'(blocks_left), 0);
    chk("ab_restart_busy", 32'(busy), 1);
    repeat (127) cyc();
    chk("ab_busy_last", 32'(busy), 1);
    cyc();
    chk("ab_busy_done", 32'(busy), 0);
    chk("ab_left_done", 32'(blocks_left), 128);
    read_cell(3'd0, 4'd1, 2'd1, "ab_r0c1");
    read_cell(3'd0, 4'd2, 2'd3, "ab_r0c2");

    // Reload in the write cycle of a destroying hit discards it.
    hit_row = 3'd0; hit_col = 4'd1; hit_valid = 1'b1;
    chk("rmw_ready", 32'(hit_ready), 1);
    cyc();
    hit_valid  = 1'b0;
    load_level = 1'b1;
    level      = 4'd1;
    #1;
    chk("rmw_no_destr", 32'(block_destroyed), 0);
    cyc();
    load_level = 1'b0;
    chk("rmw_left0", 32'(blocks_left), 0);
    chk("rmw_busy",  32'(busy), 1);
    chk("rmw_destr_init", 32'(block_destroyed), 0);
    repeat (128) cyc();
    chk("rmw_left_done", 32'(blocks_left), 128);
    chk("rmw_ready_act", 32'(hit_ready), 1);
    read_cell(3'd0, 4'd1, 2'd1, "rmw_r0c1");

    // Reset beats a simultaneous load_level.
    reset = 1'b1; load_level = 1'b1;
    cyc();
    reset = 1'b0; load_level = 1'b0;
    chk("rst_win_busy",  32'(busy), 0);
    chk("rst_win_left",  32'(blocks_left), 0);
    chk("rst_win_ready", 32'(hit_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_map_writer.md
Name: block_map_writer

Overview:
- Owns the live state of the brick field: one hit-point (HP) value per block cell in a COLS x ROWS grid.
- Collision logic writes to it through a valid/ready hit request. Each accepted hit decrements the HP of one cell.
- Provides the write-side counterpart of the block bitmap drawing path. The drawing path reads per-cell HP through a registered read port to decide whether, and in which shade, to paint each block.
- Loads a per-level HP pattern, tracks blocks remaining, and flags level completion to the game controller.

Parameters:
COLS, 16, number of block columns (power of two)
ROWS, 8, number of block rows (power of two)
HP_W, 2, width of per-cell hit points (max HP 3)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
load_level  in  1  one-cycle pulse: (re)initialise grid for level
level  in  4  level number, sampled on load_level
hit_valid  in  1  collision logic requests a hit
hit_ready  out  1  block accepts a hit this cycle
hit_col  in  $clog2(COLS)  column of hit cell
hit_row  in  $clog2(ROWS)  row of hit cell
rd_col  in  $clog2(COLS)  drawing-path read column
rd_row  in  $clog2(ROWS)  drawing-path read row
rd_hp  out  HP_W  HP of (rd_row,rd_col), registered
blocks_left  out  $clog2(COLS*ROWS)+1  cells with HP>0
block_destroyed  out  1  pulse: a cell went 1->0
level_clear  out  1  pulse: blocks_left reached 0
busy  out  1  high during INIT

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - hit_ready, rd_hp, blocks_left, block_destroyed, level_clear and busy are all 0.
  - The grid contents are undefined after reset.
- State IDLE:
  - hit_ready = 0 and rd_hp = 0.
  - load_level -> INIT.
- State INIT:
  - busy = 1 and hit_ready = 0.
  - Writes one cell per cycle in row-major order, so INIT lasts exactly COLS*ROWS cycles. The cell counter wraps from COLS*ROWS-1 to 0 on exit.
  - HP pattern by level:
    - level 0 or 1: HP 1 everywhere.
    - level 2: HP 2 everywhere.
    - level 3: HP 3 where (row+col) is even, HP 1 where it is odd.
    - level >= 4: HP 3 everywhere.
  - blocks_left is cleared on entry and counts up one per nonzero cell written.
  - Last cell written -> ACTIVE.
  - rd_hp = 0 throughout INIT.
- State ACTIVE:
  - hit_ready = 1, except in the cycle after an accepted hit.
  - The read-modify-write takes two cycles: the accept cycle reads the cell, and the next cycle writes HP-1. Throughput is therefore at most one hit per 2 cycles.
  - Hits ignored (accepted, but no state change and no pulse):
    - hit on a cell with HP 0;
    - hit_col >= COLS or hit_row >= ROWS.
  - When a write takes HP from 1 to 0:
    - block_destroyed pulses 1 cycle in the write cycle;
    - blocks_left decrements in the same cycle.
  - When blocks_left goes 1 -> 0, level_clear pulses in the following cycle and the state moves to CLEARED.
- State CLEARED:
  - hit_ready = 0 and rd_hp = 0.
  - load_level -> INIT.
- load_level in any state, including mid-INIT and mid-RMW: abort and restart INIT at cell 0 next cycle. Any pending decrement is discarded and no pulse is emitted.
- hit_valid while hit_ready = 0: not accepted. The requester holds its request.
- Read port:
  - rd_hp is registered with 1-cycle latency.
  - In ACTIVE it reflects the array value before any write occurring in the same cycle (read-before-write).
- Simultaneous reset and load_level: reset wins.

Optional Feature:
- Macro: BLOCK_MAP_SCORE_EN.
- Defined:
  - Adds output score (16 bits), reset to 0 and cleared on load_level.
  - Adds +1 per effective hit (HP>0) and a further +4 when that hit destroys the cell.
  - Saturates at 16'hFFFF.
- Undefined: no score port, no score logic.

Decomposition:
- Package block_map_pkg holds:
  - state enum (IDLE, INIT, ACTIVE, CLEARED);
  - default COLS/ROWS/HP_W;
  - hp_t;
  - the level-to-HP pattern function.
- Sub-module block_hp_ram: COLS*ROWS x HP_W storage with one synchronous write port and two registered read ports (RMW port and drawing port), read-before-write.

Test Plan:
- Reset, pulse load_level with level=1, wait 128 cycles -> busy high 128 cycles, blocks_left=128, then hit_ready=1.
- level=3, read (0,0) and (0,1) -> rd_hp=3 and 1 one cycle after the address; blocks_left=128.
- ACTIVE at level=2: hit (5,2) twice -> second hit gives block_destroyed pulse and blocks_left 128->127. A third hit on the same cell causes no change.
- Hold hit_valid continuously -> hit_ready toggles 1,0,1,0. Hit with col=16 in a wider-index build is ignored.
- level=1 field with 127 cells already cleared, hit the last cell -> block_destroyed, then level_clear pulse next cycle, hit_ready=0, state CLEARED.
- Pulse load_level at cycle 40 of INIT, and again in the cycle after a hit accept -> INIT restarts at cell 0, no destroyed pulse, blocks_left correct at end.
